// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter, the data memory and its bench.
// Optional feature macro used by the arbiter: ARB_LOCK_EN.
`timescale 1ns/1ps
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {M0, M1} master_t;

  // Memory-mapped I/O window at the top of the data memory; the arbiter treats it as plain RAM.
  localparam int unsigned IO_DISP = 253;
  localparam int unsigned IO_BTN  = 254;
  localparam int unsigned IO_SW   = 255;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// A single requester always wins; on a tie the master that did not win last time wins,
// unless lock asks the previous winner to keep the bus (only meaningful with ARB_LOCK_EN).
`timescale 1ns/1ps
module rr_pick2
  import data_mem_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last,
  input  logic       lock,
  output master_t    winner,
  output logic       valid
);

  // Pick a winner from the request vector and the previous winner.
  always_comb begin
    valid  = |req;
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = lock ? last : ((last == M0) ? M1 : M0);
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU load/store (m0) and debug/loader (m1).
// One transaction per grant, registered command to memory, read data returned one cycle later.
// Define ARB_LOCK_EN to add m0_lock/m1_lock, letting the current winner keep the bus for bursts.
`timescale 1ns/1ps
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wdata,
`ifdef ARB_LOCK_EN
  input  logic         m0_lock,
  input  logic         m1_lock,
`endif
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [N-1:0] m1_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata
);

  arb_state_t   state_reg;
  master_t      last_reg;     // owner of the current/most recent transaction
  master_t      pick_winner;
  logic         pick_valid;
  logic         lock_act;
  logic         sel_we;
  logic [N-1:0] sel_addr;
  logic [N-1:0] sel_wdata;

`ifdef ARB_LOCK_EN
  // Lock is only honoured when re-arbitrating straight after the locking master's own transaction.
  assign lock_act = (state_reg == DONE) && ((last_reg == M0) ? m0_lock : m1_lock);
`else
  assign lock_act = 1'b0;
`endif

  rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_reg),
    .lock   (lock_act),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Route the winning master's command fields toward the command registers.
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (pick_winner == M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Arbitration FSM with registered memory command and per-master response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= M1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      // Strobes are single-cycle by default.
      mem_we    <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state_reg)
        ACCESS: begin
          // mem_we still reflects the command on the bus, so a low value means a read.
          if (!mem_we) begin
            if (last_reg == M0) begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end else begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end
          end
          state_reg <= DONE;
        end
        IDLE, DONE: begin
          if (pick_valid) begin
            state_reg <= ACCESS;
            last_reg  <= pick_winner;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            if (pick_winner == M0) m0_gnt <= 1'b1;
            else                   m1_gnt <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
